// File: rtl/pow_n_pipe_arbiter.sv
// rtl/pow_n_pipe_arbiter.sv - round-robin share of one pipelined power unit between N_REQ requesters
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_vld / req_n     per-requester operand valid / operands (requester i in bits [i*W +: W])
//   req_rdy             one-hot combinational grant
//   rsp_vld / rsp_res   one-hot one-cycle result strobe / result for the strobed requester
//   pipe_n_vld / pipe_n operand issue towards the power pipe
//   pipe_res_vld / pipe_res  final-stage valid / result from the power pipe
//   busy                any operand in flight
//   err                 sticky tag/valid mismatch at the pipe output
//   issue_cnt, conflict_cnt  handshake count / multi-request cycle count
//                       (only with POW_N_PIPE_ARBITER_STATS_EN defined)

module pow_n_pipe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int RES_W   = 8,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_vld,
    input  logic [N_REQ*W-1:0]   req_n,
    output logic [N_REQ-1:0]     req_rdy,
    output logic [N_REQ-1:0]     rsp_vld,
    output logic [RES_W-1:0]     rsp_res,
    output logic                 pipe_n_vld,
    output logic [W-1:0]         pipe_n,
    input  logic                 pipe_res_vld,
    input  logic [RES_W-1:0]     pipe_res,
    output logic                 busy,
    output logic                 err
`ifdef POW_N_PIPE_ARBITER_STATS_EN
    ,
    output logic [15:0]          issue_cnt,
    output logic [15:0]          conflict_cnt
`endif
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_idx;
    logic             found;
    logic             hs;

    logic             pipe_n_vld_q;
    logic [W-1:0]     pipe_n_q, pipe_n_d;
    logic [ID_W-1:0]  id_q;

    logic [LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [LATENCY];

    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [RES_W-1:0] rsp_res_q;
    logic             err_q, err_d;
    logic             last_vld;

    // Round-robin scan starting at the pointer; the first requesting index wins.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req_vld[scan_idx]) begin
                found    = 1'b1;
                grant_id = scan_idx;
            end
        end
    end

    assign hs = found & ~rst;

    always_comb begin
        req_rdy = '0;
        if (hs) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        pipe_n_d = pipe_n_q;
        if (hs) begin
            ptr_d    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            pipe_n_d = req_n[int'(grant_id)*W +: W];
        end
    end

    // The last tag slot is aligned with the pipe's final stage; any disagreement
    // between the two valids is a lost result or a lost tag.
    assign last_vld = tag_vld_q[LATENCY-1];

    always_comb begin
        rsp_vld_d = '0;
        err_d     = err_q;
        if (pipe_res_vld && last_vld) begin
            rsp_vld_d[tag_id_q[LATENCY-1]] = 1'b1;
        end
        if (pipe_res_vld != last_vld) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            pipe_n_vld_q <= 1'b0;
            pipe_n_q     <= '0;
            id_q         <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_vld_q    <= '0;
            rsp_res_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            pipe_n_vld_q <= hs;
            pipe_n_q     <= pipe_n_d;
            if (hs) begin
                id_q <= grant_id;
            end
            // Slot 0 captures the issue currently presented on pipe_n_vld, so
            // slot LATENCY-1 is valid exactly when the pipe output is.
            tag_vld_q[0] <= pipe_n_vld_q;
            tag_id_q[0]  <= id_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            rsp_vld_q <= rsp_vld_d;
            if (rsp_vld_d != '0) begin
                rsp_res_q <= pipe_res;
            end
            err_q <= err_d;
        end
    end

    assign pipe_n_vld = pipe_n_vld_q;
    assign pipe_n     = pipe_n_q;
    assign rsp_vld    = rsp_vld_q;
    assign rsp_res    = rsp_res_q;
    assign err        = err_q;
    assign busy       = pipe_n_vld_q | (|tag_vld_q);

`ifdef POW_N_PIPE_ARBITER_STATS_EN
    logic [15:0] issue_cnt_q;
    logic [15:0] conflict_cnt_q;
    logic        multi_req;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req = (req_vld & (req_vld - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (hs) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (multi_req) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign issue_cnt    = issue_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_pow_n_pipe_arbiter.sv
// tb/tb_pow_n_pipe_arbiter.sv - self-checking bench for pow_n_pipe_arbiter

module tb_pow_n_pipe_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int RW = 8;
    localparam int L  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_vld;
    logic [N*W-1:0]    req_n;
    logic [N-1:0]      req_rdy;
    logic [N-1:0]      rsp_vld;
    logic [RW-1:0]     rsp_res;
    logic              pipe_n_vld;
    logic [W-1:0]      pipe_n;
    logic              pipe_res_vld;
    logic [RW-1:0]     pipe_res;
    logic              busy;
    logic              err;
`ifdef POW_N_PIPE_ARBITER_STATS_EN
    logic [15:0]       issue_cnt;
    logic [15:0]       conflict_cnt;
`endif

    always #5 clk = ~clk;

    pow_n_pipe_arbiter #(.N_REQ(N), .W(W), .RES_W(RW), .LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_n        (req_n),
        .req_rdy      (req_rdy),
        .rsp_vld      (rsp_vld),
        .rsp_res      (rsp_res),
        .pipe_n_vld   (pipe_n_vld),
        .pipe_n       (pipe_n),
        .pipe_res_vld (pipe_res_vld),
        .pipe_res     (pipe_res),
        .busy         (busy),
        .err          (err)
`ifdef POW_N_PIPE_ARBITER_STATS_EN
        ,
        .issue_cnt    (issue_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    function automatic logic [RW-1:0] pow5(input logic [W-1:0] n);
        logic [63:0] p;
        p = 64'(n);
        p = p * 64'(n);
        p = p * 64'(n);
        p = p * 64'(n);
        p = p * 64'(n);
        return p[RW-1:0];
    endfunction

    // Model of the power pipe: fixed latency L, never reset, so results of
    // operands issued before a reset still emerge afterwards.
    logic [L-1:0]  mv = '0;
    logic [RW-1:0] md [L];
    logic          inject = 1'b0;

    always @(posedge clk) begin
        mv[0] <= pipe_n_vld;
        md[0] <= pow5(pipe_n);
        for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
        end
    end

    assign pipe_res_vld = mv[L-1] | inject;
    assign pipe_res     = md[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0]  vld;
        logic [RW-1:0] res;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Response monitor: every strobe must match the oldest outstanding issue,
    // with the exact handshake-to-response latency.
    always @(negedge clk) begin
        if (rsp_vld !== '0) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_vld), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("rsp_vld", 32'(rsp_vld), 32'(mon_e.vld));
                check("rsp_res", 32'(rsp_res), 32'(mon_e.res));
                check("rsp_latency", 32'(cyc), 32'(mon_e.cyc + L + 2));
            end
        end
    end

    // One cycle of requester stimulus; the expected grant comes from the caller.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] n, input logic [N-1:0] exp_rdy);
        exp_t e;
        @(negedge clk);
        req_vld = v;
        req_n   = n;
        #1;
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) begin
                    e.vld = exp_rdy;
                    e.res = pow5(n[i*W +: W]);
                    e.cyc = cyc;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        step('0, '0, '0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 30) begin
            idle();
            k++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req_vld = '0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   vld;
        logic [N*W-1:0] ops;
        logic [N-1:0]   rdy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int k;
        tbl[0]  = '{4'b1111, 32'h04030201, 4'b0001};
        tbl[1]  = '{4'b1111, 32'h04030201, 4'b0010};
        tbl[2]  = '{4'b1111, 32'h04030201, 4'b0100};
        tbl[3]  = '{4'b1111, 32'h04030201, 4'b1000};
        tbl[4]  = '{4'b1111, 32'h04030201, 4'b0001};
        tbl[5]  = '{4'b0010, 32'h00000500, 4'b0010};
        tbl[6]  = '{4'b1001, 32'h07000006, 4'b1000};
        tbl[7]  = '{4'b1001, 32'h07000006, 4'b0001};
        tbl[8]  = '{4'b0000, 32'h00000000, 4'b0000};
        tbl[9]  = '{4'b0001, 32'h00000009, 4'b0001};
        tbl[10] = '{4'b0110, 32'h000B0A00, 4'b0010};
        tbl[11] = '{4'b0110, 32'h000B0A00, 4'b0100};
        tbl[12] = '{4'b0011, 32'h00000D0C, 4'b0001};
        tbl[13] = '{4'b1100, 32'h0F0E0000, 4'b0100};
        tbl[14] = '{4'b0000, 32'h00000000, 4'b0000};

        rst     = 1'b1;
        req_vld = '0;
        req_n   = '0;

        // Reset state; grants must stay off while rst is high.
        step(4'b1111, 32'h04030201, 4'b0000);
        step(4'b1111, 32'h04030201, 4'b0000);
        check("rst_pipe_n_vld", 32'(pipe_n_vld), 32'd0);
        check("rst_pipe_n", 32'(pipe_n), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_res", 32'(rsp_res), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst     = 1'b0;
        req_vld = '0;

        // Single requester, operand 2 -> 32 at handshake + L + 2.
        step(4'b0001, 32'h00000002, 4'b0001);
        for (int i = 1; i <= 7; i++) begin
            idle();
            if (i == 1) begin
                check("issue_vld", 32'(pipe_n_vld), 32'd1);
                check("issue_n", 32'(pipe_n), 32'd2);
            end
            if (i == 2) check("issue_gap", 32'(pipe_n_vld), 32'd0);
            if (i == 5) check("busy_inflight", 32'(busy), 32'd1);
            if (i == 7) check("busy_idle", 32'(busy), 32'd0);
        end
        drain();

        // Arbitration table from a fresh pointer.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].vld, tbl[i].ops, tbl[i].rdy);
        end
        drain();
        check("no_err_after_traffic", 32'(err), 32'd0);

        // Orphan result with nothing in flight.
        for (int i = 0; i < 3; i++) idle();
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        check("orphan_err", 32'(err), 32'd1);
        check("orphan_no_rsp", 32'(rsp_vld), 32'd0);
        for (int i = 0; i < 3; i++) idle();
        check("err_sticky", 32'(err), 32'd1);
        do_reset();
        #1;
        check("err_cleared", 32'(err), 32'd0);

        // Reset with two operands in flight: their results become orphans.
        step(4'b0001, 32'h00000002, 4'b0001);
        step(4'b0010, 32'h00000300, 4'b0010);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = '0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err0", 32'(err), 32'd0);
        k = 0;
        while (err !== 1'b1 && k < 12) begin
            idle();
            k++;
        end
        check("midrst_err1", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) idle();

`ifdef POW_N_PIPE_ARBITER_STATS_EN
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 32'h04030201, 4'(1 << (i % 4)));
        end
        idle();
        check("issue_cnt", 32'(issue_cnt), 32'd8);
        check("conflict_cnt", 32'(conflict_cnt), 32'd8);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
